// File: rtl/tristate_bus_receiver.sv
// Receiver for the shared active-low tristate bus: synchronises bus/strobe, captures
// re-inverted words into a FWFT FIFO, and returns an active-low ack via a tristate enable.
module tristate_bus_receiver #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               bus_n,
    input  logic                           strobe_n,
    output logic                           ack_n,
    output logic                           ack_oe,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           overflow,
    input  logic                           clr_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, RELEASE} ack_state_t;

    logic [SYNC_STAGES-1:0]            strobe_sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] bus_sync_q;
    logic                              strobe_s;
    logic [WIDTH-1:0]                  bus_s;
    logic                              strobe_prev_q;
    logic                              det_q;
    logic [WIDTH-1:0]                  cap_q;

    logic [WIDTH-1:0]                  mem_q [DEPTH];
    logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic [WIDTH-1:0]                  last_q;
    logic                              overflow_q, overflow_d;

    ack_state_t                        state_q;
    logic                              ack_n_q;
    logic                              ack_oe_q;

    logic                              pop;
    logic                              room;
    logic                              push;
    logic                              drop;

    assign strobe_s = strobe_sync_q[SYNC_STAGES-1];
    assign bus_s    = bus_sync_q[SYNC_STAGES-1];

    // Synchronisers idle at all-ones so a reset never looks like a strobe fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_sync_q <= '1;
            bus_sync_q    <= '1;
            strobe_prev_q <= 1'b1;
            det_q         <= 1'b0;
            cap_q         <= '0;
        end else begin
            strobe_sync_q <= {strobe_sync_q[SYNC_STAGES-2:0], strobe_n};
            bus_sync_q    <= {bus_sync_q[SYNC_STAGES-2:0], bus_n};
            strobe_prev_q <= strobe_s;
            det_q         <= strobe_prev_q & ~strobe_s;
            cap_q         <= ~bus_s;
        end
    end

    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid & rd_ready;
    assign room     = (count_q < FULL_CNT) | pop;
    assign push     = det_q & room;
    assign drop     = det_q & ~room;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (clr_overflow)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= cap_q;
    end

    // last_q shadows the displayed head so rd_data holds its value once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (rd_valid)
                last_q <= mem_q[rd_ptr_q];
        end
    end

    // RELEASE drives the line high for one cycle before floating it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_n_q  <= 1'b1;
            ack_oe_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q  <= ACK;
                        ack_n_q  <= 1'b0;
                        ack_oe_q <= 1'b1;
                    end
                end
                ACK: begin
                    if (strobe_s) begin
                        state_q  <= RELEASE;
                        ack_n_q  <= 1'b1;
                        ack_oe_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (push) begin
                        state_q  <= ACK;
                        ack_n_q  <= 1'b0;
                        ack_oe_q <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        ack_n_q  <= 1'b1;
                        ack_oe_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ack_n_q  <= 1'b1;
                    ack_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack_n    = ack_n_q;
    assign ack_oe   = ack_oe_q;
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : last_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_tristate_bus_receiver.sv
// Directed bench for tristate_bus_receiver: handshake timing, FIFO order, overflow and reset.
module tb_tristate_bus_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_n;
    logic       strobe_n;
    logic       ack_n;
    logic       ack_oe;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] count;
    logic       overflow;
    logic       clr_overflow;

    int n_checks = 0;
    int n_errors = 0;

    tristate_bus_receiver #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_n        (bus_n),
        .strobe_n     (strobe_n),
        .ack_n        (ack_n),
        .ack_oe       (ack_oe),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    // Strobe falls before edge k and rises before edge k+6; returns just after edge k+9.
    task automatic send(input logic [7:0] b, input bit pop_on_det, input bit clr_on_det,
                        input bit exp_ack, input string tag);
        bus_n = b;
        repeat (3) tick();
        strobe_n = 1'b0;
        repeat (3) tick();
        if (pop_on_det) rd_ready = 1'b1;
        if (clr_on_det) clr_overflow = 1'b1;
        tick();
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
        check({tag, " ack_n@k+3"},  ack_n,  !exp_ack);
        check({tag, " ack_oe@k+3"}, ack_oe, exp_ack);
        repeat (2) tick();
        strobe_n = 1'b1;
        repeat (2) tick();
        check({tag, " ack_n@k+7"},  ack_n,  !exp_ack);
        tick();
        check({tag, " ack_n@rel"},  ack_n,  1'b1);
        check({tag, " ack_oe@rel"}, ack_oe, exp_ack);
        tick();
        check({tag, " ack_oe@idle"}, ack_oe, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_q [$];
        rst_n = 1'b0; bus_n = 8'hFF; strobe_n = 1'b1; rd_ready = 1'b0; clr_overflow = 1'b0;
        repeat (2) tick();
        check("rst ack_n",    ack_n,    1'b1);
        check("rst ack_oe",   ack_oe,   1'b0);
        check("rst rd_valid", rd_valid, 1'b0);
        check("rst rd_data",  rd_data,  8'h00);
        check("rst count",    count,    3'd0);
        check("rst overflow", overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single word with cycle-exact latency.
        bus_n = 8'h5A;
        repeat (3) tick();
        strobe_n = 1'b0;
        repeat (3) tick();
        check("single rd_valid@k+2", rd_valid, 1'b0);
        tick();
        check("single rd_valid@k+3", rd_valid, 1'b1);
        check("single rd_data",      rd_data,  8'hA5);
        check("single ack_n@k+3",    ack_n,    1'b0);
        check("single ack_oe@k+3",   ack_oe,   1'b1);
        check("single count",        count,    3'd1);
        repeat (2) tick();
        strobe_n = 1'b1;
        repeat (2) tick();
        check("single ack_n@k+7", ack_n, 1'b0);
        tick();
        check("single rel ack_n",  ack_n,  1'b1);
        check("single rel ack_oe", ack_oe, 1'b1);
        tick();
        check("single idle ack_oe", ack_oe, 1'b0);
        pop_one();
        check("single drained count", count,    3'd0);
        check("single drained valid", rd_valid, 1'b0);
        check("single hold rd_data",  rd_data,  8'hA5);
        pop_one();
        check("empty pop ignored", count, 3'd0);

        // Fill to DEPTH, then one dropped word.
        send(8'hFE, 0, 0, 1, "fill0");
        send(8'hFD, 0, 0, 1, "fill1");
        send(8'hFB, 0, 0, 1, "fill2");
        send(8'hF7, 0, 0, 1, "fill3");
        check("full count", count, 3'd4);
        check("full head",  rd_data, 8'h01);
        send(8'hEF, 0, 0, 0, "drop");
        check("drop overflow", overflow, 1'b1);
        check("drop count",    count,    3'd4);
        exp_q = '{8'h01, 8'h02, 8'h04, 8'h08};
        foreach (exp_q[i]) begin
            check($sformatf("drain%0d", i), rd_data, exp_q[i]);
            pop_one();
        end
        check("drained count", count, 3'd0);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("clr overflow", overflow, 1'b0);

        // Full FIFO with a pop on the detect cycle accepts the new word.
        send(8'hFE, 0, 0, 1, "refill0");
        send(8'hFD, 0, 0, 1, "refill1");
        send(8'hFB, 0, 0, 1, "refill2");
        send(8'hF7, 0, 0, 1, "refill3");
        send(8'h00, 1, 0, 1, "pushpop");
        check("pushpop count",    count,    3'd4);
        check("pushpop overflow", overflow, 1'b0);
        check("pushpop head",     rd_data,  8'h02);

        // Drop and clear on the same cycle: set wins.
        send(8'h33, 0, 1, 0, "race");
        check("race overflow", overflow, 1'b1);
        check("race count",    count,    3'd4);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("race clear", overflow, 1'b0);
        exp_q = '{8'h02, 8'h04, 8'h08, 8'hFF};
        foreach (exp_q[i]) begin
            check($sformatf("drain2_%0d", i), rd_data, exp_q[i]);
            pop_one();
        end

        // Ten single-word round trips walk both pointers past the wrap point.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] v;
            v = 8'(i);
            send(~v, 0, 0, 1, $sformatf("wrap%0d", i));
            check($sformatf("wrap%0d data", i),  rd_data, v);
            check($sformatf("wrap%0d count", i), count,   3'd1);
            pop_one();
            check($sformatf("wrap%0d empty", i), count, 3'd0);
        end

        // Reset asserted between edges while acknowledging.
        bus_n = 8'hC3;
        repeat (3) tick();
        strobe_n = 1'b0;
        repeat (4) tick();
        check("pre-reset ack_n", ack_n, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async ack_oe",   ack_oe,   1'b0);
        check("async ack_n",    ack_n,    1'b1);
        check("async count",    count,    3'd0);
        check("async rd_valid", rd_valid, 1'b0);
        strobe_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
